// File: rtl/pi_permute_engine_pkg.sv
// Shared constants, FSM state type and modulo-5 helper for the pi lane permutation engine.
package pi_permute_engine_pkg;

    localparam int unsigned GRID           = 5;
    localparam int unsigned N_LANES        = 25;
    localparam int unsigned STEPS_PER_PASS = 24;
    localparam int unsigned START_POS      = 1;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StStep,
        StDone
    } state_e;

    // Operands are always in 0..4, so the sum never exceeds 8 and one subtraction suffices.
    function automatic logic [2:0] add_mod5(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
    endfunction

endpackage

// File: rtl/pi_index_map.sv
// Combinational destination lookup for one lane position, forward or inverse pi mapping.
module pi_index_map
    import pi_permute_engine_pkg::*;
(
    input  logic [2:0] x_i,
    input  logic [2:0] y_i,
    input  logic       inverse_i,
    output logic [2:0] x_o,
    output logic [2:0] y_o,
    output logic [4:0] idx_o
);

    logic [2:0] x2;
    logic [2:0] y2;
    logic [2:0] y3;

    assign x2 = add_mod5(x_i, x_i);
    assign y2 = add_mod5(y_i, y_i);
    assign y3 = add_mod5(y2, y_i);

    always_comb begin
        if (inverse_i) begin
            x_o = add_mod5(x_i, y3);
            y_o = x_i;
        end else begin
            x_o = y_i;
            y_o = add_mod5(x2, y3);
        end
    end

    assign idx_o = 5'({x_o, 2'b00}) + 5'(x_o) + 5'(y_o);

endmodule

// File: rtl/pi_permute_engine.sv
// Serial in-place pi permutation of a 5x5 lane state: one lane moved per cycle around the
// single 24-lane cycle, with a carry register holding the displaced lane.
module pi_permute_engine
    import pi_permute_engine_pkg::*;
#(
    parameter int unsigned LANE_W = 1,
    parameter int unsigned PASS_W = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        initLine,
    input  logic [N_LANES*LANE_W-1:0]   line,
    input  logic                        start,
    input  logic                        inverse,
    input  logic [PASS_W-1:0]           passes,
    output logic                        busy,
    output logic                        done,
    output logic [N_LANES*LANE_W-1:0]   mem
);

    state_e              state_q;
    logic [LANE_W-1:0]   lanes_q [N_LANES];
    logic [LANE_W-1:0]   carry_q;
    logic [2:0]          pos_x_q;
    logic [2:0]          pos_y_q;
    logic [4:0]          step_q;
    logic [PASS_W-1:0]   passes_left_q;
    logic                inv_q;
    logic                busy_q;
    logic                done_q;

    logic [2:0]          dst_x;
    logic [2:0]          dst_y;
    logic [4:0]          dst_idx;

    pi_index_map u_index_map (
        .x_i       (pos_x_q),
        .y_i       (pos_y_q),
        .inverse_i (inv_q),
        .x_o       (dst_x),
        .y_o       (dst_y),
        .idx_o     (dst_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            for (int unsigned k = 0; k < N_LANES; k++) begin
                lanes_q[k] <= '0;
            end
            carry_q       <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            step_q        <= '0;
            passes_left_q <= '0;
            inv_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // The load lands on the same edge as an accepted start, so FETCH sees it.
                    if (initLine) begin
                        for (int unsigned k = 0; k < N_LANES; k++) begin
                            lanes_q[k] <= line[k*LANE_W +: LANE_W];
                        end
                    end
                    if (start) begin
                        inv_q         <= inverse;
                        passes_left_q <= passes;
                        if (passes == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StFetch;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StFetch: begin
                    carry_q <= lanes_q[START_POS];
                    pos_x_q <= '0;
                    pos_y_q <= 3'(START_POS);
                    step_q  <= '0;
                    state_q <= StStep;
                end
                StStep: begin
                    lanes_q[dst_idx] <= carry_q;
                    carry_q          <= lanes_q[dst_idx];
                    pos_x_q          <= dst_x;
                    pos_y_q          <= dst_y;
                    step_q           <= step_q + 5'd1;
                    if (step_q == 5'(STEPS_PER_PASS - 1)) begin
                        passes_left_q <= passes_left_q - PASS_W'(1);
                        if (passes_left_q == PASS_W'(1)) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        mem = '0;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            mem[k*LANE_W +: LANE_W] = lanes_q[k];
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule
